// File: rtl/sdram_arb_pkg.sv
// ============================================================================
// Module   : sdram_arb_pkg
// Brief    : Shared types and constants for the two-port SDRAM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

    localparam int NUM_PORTS       = 2;
    localparam int DEFAULT_TIMEOUT = 255;
    // Wide enough for the largest legal timeout (1023).
    localparam int CNT_W           = 10;
    localparam int ADDR_W          = 24;
    localparam int DATA_W          = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    function automatic op_t req_to_op(input logic req_write);
        return req_write ? OP_WR : OP_RD;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_arbiter_if.sv
// ============================================================================
// Module   : sdram_arbiter_if
// Brief    : Requester-port and SDRAM-controller signals of the arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sdram_arbiter_if;
    import sdram_arb_pkg::*;

    logic              p0_req_read;
    logic              p0_req_write;
    logic [ADDR_W-1:0] p0_address;
    logic [DATA_W-1:0] p0_data_in;
    logic [DATA_W-1:0] p0_data_out;
    logic              p0_ack;
    logic              p0_err;

    logic              p1_req_read;
    logic              p1_req_write;
    logic [ADDR_W-1:0] p1_address;
    logic [DATA_W-1:0] p1_data_in;
    logic [DATA_W-1:0] p1_data_out;
    logic              p1_ack;
    logic              p1_err;

    logic [ADDR_W-1:0] sd_address;
    logic              sd_req_read;
    logic              sd_req_write;
    logic [DATA_W-1:0] sd_data_in;
    logic [DATA_W-1:0] sd_data_out;
    logic              sd_data_valid;
    logic              sd_write_complete;

    logic              grant;
    logic              busy;

    // master: the arbiter itself; slave: requesters plus SDRAM controller.
    modport master (
        input  p0_req_read, p0_req_write, p0_address, p0_data_in,
        input  p1_req_read, p1_req_write, p1_address, p1_data_in,
        input  sd_data_out, sd_data_valid, sd_write_complete,
        output p0_data_out, p0_ack, p0_err,
        output p1_data_out, p1_ack, p1_err,
        output sd_address, sd_req_read, sd_req_write, sd_data_in,
        output grant, busy
    );

    modport slave (
        output p0_req_read, p0_req_write, p0_address, p0_data_in,
        output p1_req_read, p1_req_write, p1_address, p1_data_in,
        output sd_data_out, sd_data_valid, sd_write_complete,
        input  p0_data_out, p0_ack, p0_err,
        input  p1_data_out, p1_ack, p1_err,
        input  sd_address, sd_req_read, sd_req_write, sd_data_in,
        input  grant, busy
    );

endinterface

`default_nettype wire

// File: rtl/sdram_arb_pick.sv
// ============================================================================
// Module   : sdram_arb_pick
// Brief    : Combinational winner selection; SDRAM_ARB_RR_EN selects
//            round-robin, otherwise port 0 has fixed priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  wire logic [NUM_PORTS-1:0] i_req,
`ifdef SDRAM_ARB_RR_EN
    input  wire logic                 i_last_grant,
`endif
    output logic                      o_winner,
    output logic                      o_valid
);

    always_comb begin
        o_valid = |i_req;
`ifdef SDRAM_ARB_RR_EN
        // On contention the port that did not win last time goes first.
        if (&i_req) begin
            o_winner = ~i_last_grant;
        end else begin
            o_winner = i_req[1];
        end
`else
        o_winner = ~i_req[0] & i_req[1];
`endif
    end

endmodule

`default_nettype wire

// File: rtl/sdram_arbiter.sv
// ============================================================================
// Module   : sdram_arbiter
// Brief    : Two-port arbiter serialising requests onto one SDRAM controller
//            with a completion timeout; SDRAM_ARB_RR_EN enables round-robin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  wire logic       CLOCK_100,
    input  wire logic       rst,
    sdram_arbiter_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    op_t               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout0_q, dout0_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;
    logic              dv_q, dv_d;
    logic              dv_prev_q, dv_prev_d;
    logic              wc_q, wc_d;
    logic              wc_prev_q, wc_prev_d;
`ifdef SDRAM_ARB_RR_EN
    logic              last_q, last_d;
`endif

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_dv_rise;
    logic                 w_wc_rise;

    assign w_req = {bus.p1_req_read | bus.p1_req_write,
                    bus.p0_req_read | bus.p0_req_write};

    sdram_arb_pick u_pick (
        .i_req        (w_req),
`ifdef SDRAM_ARB_RR_EN
        .i_last_grant (last_q),
`endif
        .o_winner     (w_pick_idx),
        .o_valid      (w_pick_valid)
    );

    // Completion levels are sampled once; edges come from sample vs. previous sample.
    assign w_dv_rise = dv_q & ~dv_prev_q;
    assign w_wc_rise = wc_q & ~wc_prev_q;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        dout0_d   = dout0_q;
        dout1_d   = dout1_q;
        dv_d      = bus.sd_data_valid;
        dv_prev_d = dv_q;
        wc_d      = bus.sd_write_complete;
        wc_prev_d = wc_q;
`ifdef SDRAM_ARB_RR_EN
        last_d    = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    grant_d = w_pick_idx;
                    if (w_pick_idx) begin
                        op_d    = req_to_op(bus.p1_req_write);
                        addr_d  = bus.p1_address;
                        wdata_d = bus.p1_data_in;
                    end else begin
                        op_d    = req_to_op(bus.p0_req_write);
                        addr_d  = bus.p0_address;
                        wdata_d = bus.p0_data_in;
                    end
`ifdef SDRAM_ARB_RR_EN
                    last_d  = w_pick_idx;
`endif
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // A completion edge outranks a coincident timeout.
                if (op_q == OP_RD && w_dv_rise) begin
                    if (grant_q) begin
                        dout1_d = bus.sd_data_out;
                    end else begin
                        dout0_d = bus.sd_data_out;
                    end
                    state_d = ST_DONE;
                end else if (op_q == OP_WR && w_wc_rise) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_100 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RD;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_q   <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            dout0_q   <= '0;
            dout1_q   <= '0;
            dv_q      <= 1'b0;
            dv_prev_q <= 1'b0;
            wc_q      <= 1'b0;
            wc_prev_q <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            dout0_q   <= dout0_d;
            dout1_q   <= dout1_d;
            dv_q      <= dv_d;
            dv_prev_q <= dv_prev_d;
            wc_q      <= wc_d;
            wc_prev_q <= wc_prev_d;
`ifdef SDRAM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign bus.sd_address   = addr_q;
    assign bus.sd_data_in   = wdata_q;
    assign bus.sd_req_read  = (state_q == ST_ISSUE) && (op_q == OP_RD);
    assign bus.sd_req_write = (state_q == ST_ISSUE) && (op_q == OP_WR);
    assign bus.grant        = grant_q;
    assign bus.busy         = (state_q != ST_IDLE);

    assign bus.p0_ack       = (state_q == ST_DONE) && !grant_q;
    assign bus.p1_ack       = (state_q == ST_DONE) &&  grant_q;
    assign bus.p0_err       = (state_q == ST_DONE) && !grant_q && err_q;
    assign bus.p1_err       = (state_q == ST_DONE) &&  grant_q && err_q;
    assign bus.p0_data_out  = dout0_q;
    assign bus.p1_data_out  = dout1_q;

endmodule

`default_nettype wire
